// File: rtl/mbinit_repairmb_gen.sv
// MBINIT.REPAIRMB sequencer: initiator handshake, lane-repair evaluation, and a
// concurrent responder sharing one sideband TX channel.
module mbinit_repairmb_gen #(
  parameter int NUM_LANES   = 16,
  parameter int TIMEOUT_CYC = 8000,
  parameter int CNT_W       = 13
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [3:0]           i_rx_msg,
  input  logic [1:0]           i_rx_info,
  input  logic                 i_msg_valid,
  input  logic                 i_sb_busy_fall,
  input  logic                 i_pattern_done,
  input  logic [NUM_LANES-1:0] i_pattern_result,
  output logic [3:0]           o_tx_msg,
  output logic [1:0]           o_tx_info,
  output logic                 o_tx_valid,
  output logic                 o_pattern_en,
  output logic [1:0]           o_lanes_tx,
  output logic [1:0]           o_lanes_rx,
  output logic                 o_done,
  output logic                 o_train_error
);

  localparam int HALF = NUM_LANES / 2;

  localparam logic [3:0] MSG_START_REQ  = 4'd1;
  localparam logic [3:0] MSG_START_RESP = 4'd2;
  localparam logic [3:0] MSG_DEG_REQ    = 4'd3;
  localparam logic [3:0] MSG_DEG_RESP   = 4'd4;
  localparam logic [3:0] MSG_END_REQ    = 4'd5;
  localparam logic [3:0] MSG_END_RESP   = 4'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_START, S_WAIT_START, S_PATTERN, S_EVAL, S_SEND_DEG,
    S_WAIT_DEG, S_SEND_END, S_WAIT_END, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    OWN_NONE, OWN_START, OWN_DEG, OWN_END, OWN_INIT
  } owner_t;

  state_t               r_state;
  owner_t               r_owner;
  logic                 r_pend_start;
  logic                 r_pend_deg;
  logic                 r_pend_end;
  logic                 r_partner_end;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_LANES-1:0] r_result;

  logic       w_release;
  logic       w_free;
  logic       w_pend_start_eff;
  logic       w_pend_deg_eff;
  logic       w_pend_end_eff;
  logic       w_init_send;
  logic       w_rx_start_req;
  logic       w_rx_deg_req;
  logic       w_rx_end_req;
  logic       w_wait_hit;
  logic       w_is_wait;
  logic       w_go_error;
  logic [1:0] w_eval;
  owner_t     w_grant;
  logic [3:0] w_grant_msg;
  logic [1:0] w_grant_info;

  function automatic logic [1:0] f_lane_map(input logic [NUM_LANES-1:0] res);
    if (&res)                         return 2'b11;
    else if (&res[HALF-1:0])          return 2'b01;
    else if (&res[NUM_LANES-1:HALF])  return 2'b10;
    else                              return 2'b00;
  endfunction

  assign w_release        = (r_owner != OWN_NONE) && i_sb_busy_fall;
  assign w_free           = (r_owner == OWN_NONE) || w_release;
  assign w_pend_start_eff = r_pend_start && !(w_release && (r_owner == OWN_START));
  assign w_pend_deg_eff   = r_pend_deg   && !(w_release && (r_owner == OWN_DEG));
  assign w_pend_end_eff   = r_pend_end   && !(w_release && (r_owner == OWN_END));
  assign w_init_send      = ((r_state == S_SEND_START) || (r_state == S_SEND_DEG) ||
                             (r_state == S_SEND_END)) &&
                            !(w_release && (r_owner == OWN_INIT));
  assign w_rx_start_req   = i_msg_valid && (i_rx_msg == MSG_START_REQ);
  assign w_rx_deg_req     = i_msg_valid && (i_rx_msg == MSG_DEG_REQ);
  assign w_rx_end_req     = i_msg_valid && (i_rx_msg == MSG_END_REQ);
  assign w_is_wait        = (r_state == S_WAIT_START) || (r_state == S_WAIT_DEG) ||
                            (r_state == S_WAIT_END);
  assign w_eval           = f_lane_map(r_result);
  assign w_go_error       = (w_is_wait && !w_wait_hit && (r_cnt == CNT_W'(TIMEOUT_CYC - 1))) ||
                            ((r_state == S_EVAL) && (w_eval == 2'b00));
  assign o_done           = (r_state == S_DONE) && r_partner_end;

  // Expected response for the current WAIT_* state.
  always_comb begin
    w_wait_hit = 1'b0;
    case (r_state)
      S_WAIT_START: w_wait_hit = i_msg_valid && (i_rx_msg == MSG_START_RESP);
      S_WAIT_DEG:   w_wait_hit = i_msg_valid && (i_rx_msg == MSG_DEG_RESP);
      S_WAIT_END:   w_wait_hit = i_msg_valid && (i_rx_msg == MSG_END_RESP);
      default:      w_wait_hit = 1'b0;
    endcase
  end

  // TX arbitration: responses outrank the initiator; the channel can be handed
  // over on the same cycle the previous owner is released.
  always_comb begin
    w_grant      = OWN_NONE;
    w_grant_msg  = 4'd0;
    w_grant_info = 2'b00;
    if (w_free && (r_state != S_ERROR)) begin
      if (w_pend_start_eff) begin
        w_grant     = OWN_START;
        w_grant_msg = MSG_START_RESP;
      end else if (w_pend_deg_eff) begin
        w_grant      = OWN_DEG;
        w_grant_msg  = MSG_DEG_RESP;
        w_grant_info = o_lanes_rx;
      end else if (w_pend_end_eff) begin
        w_grant     = OWN_END;
        w_grant_msg = MSG_END_RESP;
      end else if (w_init_send) begin
        w_grant = OWN_INIT;
        case (r_state)
          S_SEND_START: w_grant_msg = MSG_START_REQ;
          S_SEND_DEG: begin
            w_grant_msg  = MSG_DEG_REQ;
            w_grant_info = o_lanes_tx;
          end
          S_SEND_END:   w_grant_msg = MSG_END_REQ;
          default:      w_grant     = OWN_NONE;
        endcase
      end else begin
        w_grant = OWN_NONE;
      end
    end else begin
      w_grant = OWN_NONE;
    end
  end

  // Initiator FSM, responder flags and the registered TX channel.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_NONE;
      r_pend_start  <= 1'b0;
      r_pend_deg    <= 1'b0;
      r_pend_end    <= 1'b0;
      r_partner_end <= 1'b0;
      r_cnt         <= '0;
      r_result      <= '0;
      o_tx_msg      <= 4'd0;
      o_tx_info     <= 2'b00;
      o_tx_valid    <= 1'b0;
      o_pattern_en  <= 1'b0;
      o_lanes_tx    <= 2'b11;
      o_lanes_rx    <= 2'b11;
      o_train_error <= 1'b0;
    end else if (r_state == S_ERROR) begin
      r_owner       <= OWN_NONE;
      o_tx_msg      <= 4'd0;
      o_tx_info     <= 2'b00;
      o_tx_valid    <= 1'b0;
      o_pattern_en  <= 1'b0;
      o_train_error <= 1'b1;
    end else if ((r_state == S_DONE) && !i_start) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_NONE;
      r_pend_start  <= 1'b0;
      r_pend_deg    <= 1'b0;
      r_pend_end    <= 1'b0;
      r_partner_end <= 1'b0;
      r_cnt         <= '0;
      o_tx_msg      <= 4'd0;
      o_tx_info     <= 2'b00;
      o_tx_valid    <= 1'b0;
      o_pattern_en  <= 1'b0;
      o_lanes_tx    <= 2'b11;
      o_lanes_rx    <= 2'b11;
    end else begin
      r_pend_start <= w_pend_start_eff || w_rx_start_req;
      r_pend_deg   <= w_pend_deg_eff   || w_rx_deg_req;
      r_pend_end   <= w_pend_end_eff   || w_rx_end_req;
      if (w_rx_deg_req) begin
        o_lanes_rx <= i_rx_info;
        if (i_rx_info == 2'b00) o_train_error <= 1'b1;
      end
      if (w_rx_end_req) r_partner_end <= 1'b1;

      if (w_grant != OWN_NONE) begin
        r_owner    <= w_grant;
        o_tx_valid <= 1'b1;
        o_tx_msg   <= w_grant_msg;
        o_tx_info  <= w_grant_info;
      end else if (w_release) begin
        r_owner    <= OWN_NONE;
        o_tx_valid <= 1'b0;
        o_tx_msg   <= 4'd0;
        o_tx_info  <= 2'b00;
      end

      case (r_state)
        S_IDLE: if (i_start) r_state <= S_SEND_START;
        S_SEND_START: if (w_release && (r_owner == OWN_INIT)) begin
          r_state <= S_WAIT_START;
          r_cnt   <= '0;
        end
        S_WAIT_START: if (w_wait_hit) begin
          r_state      <= S_PATTERN;
          o_pattern_en <= 1'b1;
        end else r_cnt <= r_cnt + CNT_W'(1);
        S_PATTERN: if (i_pattern_done) begin
          r_result     <= i_pattern_result;
          o_pattern_en <= 1'b0;
          r_state      <= S_EVAL;
        end
        S_EVAL: begin
          o_lanes_tx <= w_eval;
          r_state    <= S_SEND_DEG;
        end
        S_SEND_DEG: if (w_release && (r_owner == OWN_INIT)) begin
          r_state <= S_WAIT_DEG;
          r_cnt   <= '0;
        end
        S_WAIT_DEG: if (w_wait_hit) r_state <= S_SEND_END;
        else r_cnt <= r_cnt + CNT_W'(1);
        S_SEND_END: if (w_release && (r_owner == OWN_INIT)) begin
          r_state <= S_WAIT_END;
          r_cnt   <= '0;
        end
        S_WAIT_END: if (w_wait_hit) r_state <= S_DONE;
        else r_cnt <= r_cnt + CNT_W'(1);
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_ERROR;
      endcase

      // Timeout or an all-fail evaluation silences the channel immediately.
      if (w_go_error) begin
        r_state       <= S_ERROR;
        r_owner       <= OWN_NONE;
        o_tx_msg      <= 4'd0;
        o_tx_info     <= 2'b00;
        o_tx_valid    <= 1'b0;
        o_pattern_en  <= 1'b0;
        o_train_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mbinit_repairmb_gen.sv
// Directed bench: a 16-lane and an 8-lane instance driven in lockstep by a
// scripted sideband partner, with per-vector lane results.
module tb_mbinit_repairmb_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [3:0]  i_rx_msg;
  logic [1:0]  i_rx_info;
  logic        i_msg_valid;
  logic        i_sb_busy_fall;
  logic        i_pattern_done;
  logic [15:0] res16;
  logic [7:0]  res8;

  logic [3:0] msg16, msg8;
  logic [1:0] info16, info8, ltx16, ltx8, lrx16, lrx8;
  logic       val16, val8, pen16, pen8, done16, done8, err16, err8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mbinit_repairmb_gen #(.NUM_LANES(16)) u16 (
    .CLK(clk), .rst_n(rst_n), .i_start(i_start), .i_rx_msg(i_rx_msg),
    .i_rx_info(i_rx_info), .i_msg_valid(i_msg_valid), .i_sb_busy_fall(i_sb_busy_fall),
    .i_pattern_done(i_pattern_done), .i_pattern_result(res16),
    .o_tx_msg(msg16), .o_tx_info(info16), .o_tx_valid(val16), .o_pattern_en(pen16),
    .o_lanes_tx(ltx16), .o_lanes_rx(lrx16), .o_done(done16), .o_train_error(err16));

  mbinit_repairmb_gen #(.NUM_LANES(8)) u8 (
    .CLK(clk), .rst_n(rst_n), .i_start(i_start), .i_rx_msg(i_rx_msg),
    .i_rx_info(i_rx_info), .i_msg_valid(i_msg_valid), .i_sb_busy_fall(i_sb_busy_fall),
    .i_pattern_done(i_pattern_done), .i_pattern_result(res8),
    .o_tx_msg(msg8), .o_tx_info(info8), .o_tx_valid(val8), .o_pattern_en(pen8),
    .o_lanes_tx(ltx8), .o_lanes_rx(lrx8), .o_done(done8), .o_train_error(err8));

  typedef struct {
    logic [15:0] r16;
    logic [7:0]  r8;
    logic [1:0]  e16;
    logic [1:0]  e8;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_start = 1'b0; i_rx_msg = 4'd0; i_rx_info = 2'b00; i_msg_valid = 1'b0;
    i_sb_busy_fall = 1'b0; i_pattern_done = 1'b0; res16 = 16'h0000; res8 = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_msg(input logic [3:0] m, input logic [1:0] inf);
    i_msg_valid = 1'b1; i_rx_msg = m; i_rx_info = inf;
    tick();
    i_msg_valid = 1'b0; i_rx_msg = 4'd0; i_rx_info = 2'b00;
  endtask

  task automatic busy_fall();
    i_sb_busy_fall = 1'b1;
    tick();
    i_sb_busy_fall = 1'b0;
  endtask

  // Waits for a TX message, checks both instances, then lets the sideband accept it.
  task automatic wait_tx(input string nm, input logic [3:0] emsg, input logic [1:0] einfo,
                         input bit chk_info);
    int n = 0;
    while (!val16 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_valid"}, {31'd0, val16}, 32'd1);
    chk({nm, "_msg16"}, {28'd0, msg16}, {28'd0, emsg});
    chk({nm, "_msg8"},  {28'd0, msg8},  {28'd0, emsg});
    if (chk_info) begin
      chk({nm, "_info16"}, {30'd0, info16}, {30'd0, einfo});
      chk({nm, "_info8"},  {30'd0, info8},  {30'd0, einfo});
    end
    busy_fall();
  endtask

  task automatic run_flow(input int k);
    i_start = 1'b1;
    tick();
    wait_tx($sformatf("v%0d_start_req", k), 4'd1, 2'b00, 1'b0);
    send_msg(4'd2, 2'b00);
    chk($sformatf("v%0d_pattern_en", k), {30'd0, pen16, pen8}, 32'd3);
    i_pattern_done = 1'b1; res16 = vt[k].r16; res8 = vt[k].r8;
    tick();
    i_pattern_done = 1'b0;
    tick();
    chk($sformatf("v%0d_lanes_tx16", k), {30'd0, ltx16}, {30'd0, vt[k].e16});
    chk($sformatf("v%0d_lanes_tx8", k),  {30'd0, ltx8},  {30'd0, vt[k].e8});
    if (vt[k].e16 == 2'b00) begin
      int seen = 0;
      chk($sformatf("v%0d_err", k), {30'd0, err16, err8}, 32'd3);
      for (int i = 0; i < 6; i++) begin
        if (val16 || val8) seen++;
        tick();
      end
      chk($sformatf("v%0d_no_deg_req", k), seen, 32'd0);
    end else begin
      wait_tx($sformatf("v%0d_deg_req", k), 4'd3, vt[k].e16, 1'b1);
      send_msg(4'd4, 2'b00);
      wait_tx($sformatf("v%0d_end_req", k), 4'd5, 2'b00, 1'b0);
      send_msg(4'd5, 2'b00);
      wait_tx($sformatf("v%0d_end_resp", k), 4'd6, 2'b00, 1'b0);
      chk($sformatf("v%0d_done_early", k), {30'd0, done16, done8}, 32'd0);
      send_msg(4'd6, 2'b00);
      chk($sformatf("v%0d_done", k), {30'd0, done16, done8}, 32'd3);
      chk($sformatf("v%0d_no_err", k), {30'd0, err16, err8}, 32'd0);
      i_start = 1'b0;
      tick();
      chk($sformatf("v%0d_done_clr", k), {30'd0, done16, done8}, 32'd0);
    end
  endtask

  initial begin
    vt[0] = '{16'hFFFF, 8'hFF, 2'b11, 2'b11};
    vt[1] = '{16'hFF00, 8'hF0, 2'b10, 2'b10};
    vt[2] = '{16'h00FF, 8'h0F, 2'b01, 2'b01};
    vt[3] = '{16'h7FFF, 8'h7F, 2'b01, 2'b01};
    vt[4] = '{16'hFFFE, 8'hFE, 2'b10, 2'b10};
    vt[5] = '{16'h0F0F, 8'h5A, 2'b00, 2'b00};
    vt[6] = '{16'h0000, 8'h00, 2'b00, 2'b00};

    do_reset();
    chk("rst_tx", {22'd0, msg16, info16, val16, pen16, done16, err16}, 32'd0);
    chk("rst_lanes16", {28'd0, ltx16, lrx16}, 32'hF);
    chk("rst_lanes8",  {28'd0, ltx8, lrx8},   32'hF);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      run_flow(k);
    end

    // Partner START_REQ lands on the same cycle our START_REQ is accepted.
    do_reset();
    i_start = 1'b1;
    tick();
    tick();
    chk("col_own", {28'd0, msg16}, 32'd1);
    i_sb_busy_fall = 1'b1; i_msg_valid = 1'b1; i_rx_msg = 4'd1;
    tick();
    i_sb_busy_fall = 1'b0; i_msg_valid = 1'b0; i_rx_msg = 4'd0;
    tick();
    chk("col_resp_valid", {31'd0, val16}, 32'd1);
    chk("col_resp_msg", {24'd0, msg16, msg8}, 32'h22);
    busy_fall();
    send_msg(4'd2, 2'b00);
    chk("col_pattern_en", {30'd0, pen16, pen8}, 32'd3);

    // No START_RESP: timeout fires exactly TIMEOUT_CYC cycles into WAIT_START.
    do_reset();
    i_start = 1'b1;
    tick();
    tick();
    busy_fall();
    for (int i = 0; i < 7999; i++) tick();
    chk("to_before", {30'd0, err16, err8}, 32'd0);
    tick();
    chk("to_err", {30'd0, err16, err8}, 32'd3);
    chk("to_txv", {30'd0, val16, val8}, 32'd0);

    // Responder: repeat DEGRADE_REQ absorbed, then info 00 flags error.
    do_reset();
    send_msg(4'd3, 2'b01);
    send_msg(4'd3, 2'b01);
    chk("deg_lrx01", {28'd0, lrx16, lrx8}, 32'h5);
    wait_tx("deg_resp01", 4'd4, 2'b01, 1'b1);
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (val16) seen++;
        tick();
      end
      chk("deg_absorbed", seen, 32'd0);
    end
    chk("deg_no_err", {30'd0, err16, err8}, 32'd0);
    send_msg(4'd3, 2'b00);
    chk("deg_lrx00", {28'd0, lrx16, lrx8}, 32'h0);
    chk("deg_err", {30'd0, err16, err8}, 32'd3);
    wait_tx("deg_resp00", 4'd4, 2'b00, 1'b1);

    // Async reset while a message is on the channel.
    do_reset();
    i_start = 1'b1;
    tick();
    tick();
    chk("arst_pre_valid", {31'd0, val16}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", {22'd0, msg16, info16, val16, pen16, done16, err16}, 32'd0);
    chk("arst_lanes", {24'd0, ltx16, lrx16, ltx8, lrx8}, 32'hFF);
    i_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_quiet", {30'd0, val16, val8}, 32'd0);
    run_flow(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbinit_repairmb_gen.md
MBINIT_REPAIRMB_GEN -- requirements
Module: mbinit_repairmb_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_LANES  16  mainband data lanes; even, >=2
  TIMEOUT_CYC  8000  cycles allowed in any WAIT_* state before error
  CNT_W  13  timeout counter width; 2^CNT_W > TIMEOUT_CYC
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLK  in  1  clock
  rst_n  in  1  async active-low reset
  i_start  in  1  level; REVERSALMB complete, starts REPAIRMB
  i_rx_msg  in  4  received sideband message code
  i_rx_info  in  2  lane-map field of received message
  i_msg_valid  in  1  i_rx_msg/i_rx_info valid, one-cycle pulse
  i_sb_busy_fall  in  1  sideband accepted current TX message
  i_pattern_done  in  1  Tx-initiated data-to-clock pattern finished
  i_pattern_result  in  NUM_LANES  per-lane pass (1) / fail (0)
  o_tx_msg  out  4  message code to send
  o_tx_info  out  2  lane-map field to send
  o_tx_valid  out  1  o_tx_msg valid; held until i_sb_busy_fall
  o_pattern_en  out  1  request pattern test, all lanes
  o_lanes_tx  out  2  local TX lane map
  o_lanes_rx  out  2  partner-decided RX lane map
  o_done  out  1  REPAIRMB complete, both sides
  o_train_error  out  1  sticky error
REQ-003 Message codes SHALL be: 1 START_REQ, 2 START_RESP, 3 DEGRADE_REQ, 4 DEGRADE_RESP, 5 END_REQ, 6 END_RESP; others ignored.
REQ-004 Lane map SHALL be: 11 all lanes, 01 lower half, 10 upper half, 00 none.

Function
REQ-005 Initiator FSM states SHALL be IDLE, SEND_START, WAIT_START, PATTERN, EVAL, SEND_DEG, WAIT_DEG, SEND_END, WAIT_END, DONE, ERROR.
REQ-006 IDLE->SEND_START when i_start=1; SEND_x->WAIT_x on i_sb_busy_fall while the initiator owns TX.
REQ-007 WAIT_START->PATTERN on i_msg_valid with START_RESP; WAIT_DEG->SEND_END on DEGRADE_RESP; WAIT_END->DONE on END_RESP.
REQ-008 PATTERN: o_pattern_en=1 until i_pattern_done, then EVAL; i_pattern_result sampled on the i_pattern_done cycle.
REQ-009 EVAL (one cycle): all lanes pass->11; else lower NUM_LANES/2 all pass->01; else upper half all pass->10; else 00; result registered into o_lanes_tx.
REQ-010 EVAL result 00 SHALL go to ERROR; otherwise SEND_DEG with o_tx_info=o_lanes_tx.
REQ-011 Timeout counter SHALL clear on WAIT_* entry, increment each WAIT_* cycle, and force ERROR when it reaches TIMEOUT_CYC.
REQ-012 Responder SHALL run concurrently: START_REQ->queue START_RESP; DEGRADE_REQ->latch i_rx_info into o_lanes_rx and queue DEGRADE_RESP (info 00 also sets o_train_error); END_REQ->queue END_RESP and set partner_end.
REQ-013 Responder SHALL hold one pending flag per response type; repeat request while pending is absorbed.
REQ-014 TX arbitration: a pending response wins when channel idle; an owner keeps the channel until i_sb_busy_fall; priority START_RESP>DEGRADE_RESP>END_RESP>initiator.
REQ-015 o_tx_msg/o_tx_info SHALL remain stable while o_tx_valid=1; o_tx_msg=0 when o_tx_valid=0.
REQ-016 o_done SHALL be 1 exactly when initiator is DONE and partner_end=1; held until i_start falls, then all state returns to IDLE.
REQ-017 ERROR SHALL set o_train_error, drop o_tx_valid/o_pattern_en, exit only via reset.
REQ-018 i_msg_valid and i_sb_busy_fall in the same cycle SHALL both be processed.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, clear pending flags, partner_end and counter, and drive all outputs to 0 except o_lanes_tx=o_lanes_rx=11.
REQ-020 Reset asserted mid-handshake SHALL abort without emitting further messages.

Verification
REQ-021 NUM_LANES=16, all pass, partner replies promptly -> START_REQ, DEGRADE_REQ info 11, END_REQ sent; o_lanes_tx=11; o_done=1.
REQ-022 Result 16'hFF00 -> o_lanes_tx=10, DEGRADE_REQ info 10; result 16'h0F0F -> ERROR, o_train_error=1, no DEGRADE_REQ.
REQ-023 Partner START_REQ arrives while initiator in SEND_START owning TX -> START_RESP sent immediately after that i_sb_busy_fall, neither lost.
REQ-024 No START_RESP for TIMEOUT_CYC cycles -> o_train_error=1 at cycle TIMEOUT_CYC, o_tx_valid=0.
REQ-025 Partner DEGRADE_REQ info 00 -> o_lanes_rx=00, o_train_error=1; NUM_LANES=8 regression repeats REQ-021/022.
REQ-026 rst_n pulsed while o_tx_valid=1 -> outputs at reset values same cycle; fresh i_start completes normally.
